keyb_decoder: RTL
=================

KEYB_DECODER -- requirements
Module: keyb_decoder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entry count (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port keyb_char  input  32  latest complete PS/2 set-2 scancode from the keyboard stage (00_00_00_XX make, 00_00_F0_XX break, 00_00_E0_XX ext make, 00_E0_F0_XX ext break).
REQ-005 SHALL have port rd_en  input  1  CPU pop request, one entry per cycle asserted.
REQ-006 SHALL have port clr_ovf  input  1  clears overflow.
REQ-007 SHALL have port ascii_out  output  8  FIFO head character, show-ahead; 8'h00 when empty.
REQ-008 SHALL have port empty  output  1  FIFO holds no entries.
REQ-009 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-010 SHALL have port count  output  5  entries held, 0..DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky: a character was dropped.
REQ-012 SHALL have port caps_on  output  1  current caps-lock state.

Function
REQ-013 SHALL register keyb_char into prev_char every cycle; a code event occurs in the cycle keyb_char != prev_char, i.e. one cycle after keyb_char changes.
REQ-014 SHALL hold an armed flag, cleared by reset, set on the first clock after reset; no code event SHALL occur while armed==0 (the stale post-reset keyb_char is absorbed, not decoded).
REQ-015 SHALL classify each event as make, break, ext make or ext break from bits [15:8] and [23:16]; any other upper-byte pattern SHALL be ignored.
REQ-016 SHALL track shift_l (12h) and shift_r (59h): set on make, cleared on break; shift = shift_l | shift_r.
REQ-017 SHALL toggle caps_on on each make of 58h; break of 58h has no effect.
REQ-018 SHALL translate makes per US map: letters 1Ch..(set-2 a-z) -> 'a'-'z', uppercase when shift XOR caps_on; digit row 45h,16h,1Eh,26h,25h,2Eh,36h,3Dh,3Eh,46h -> '0'-'9', or ")!@#$%^&*(" when shift; 29h->20h, 5Ah->0Dh, 66h->08h, 0Dh->09h, 76h->1Bh.
REQ-019 SHALL push the translated character into the FIFO in the cycle after the event (two cycles after keyb_char changes); unmapped makes, all breaks, all extended codes, and modifier keys SHALL push nothing.
REQ-020 SHALL pop on rd_en when not empty; rd_en while empty SHALL be ignored, no state change.
REQ-021 Simultaneous push and pop SHALL both occur, count unchanged, including when full (no overflow) and when empty (push only; pop ignored).
REQ-022 Push while full without pop SHALL drop the character and set overflow; FIFO contents unchanged.
REQ-023 overflow SHALL clear on clr_ovf; if clr_ovf and a drop occur in the same cycle, overflow SHALL remain 1.
REQ-024 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; full/empty derived from count.
REQ-025 ascii_out, empty, full, count SHALL reflect state after the last clock edge (no combinational path from rd_en).
REQ-026 Repeated identical scancodes (typematic) produce no event; this is accepted behaviour.

Reset
REQ-027 Asserting reset SHALL immediately force count=0, empty=1, full=0, overflow=0, caps_on=0, ascii_out=8'h00, shift_l=shift_r=0, armed=0, pointers=0, prev_char=0.
REQ-028 Reset mid-operation SHALL discard FIFO contents and any pending push.

Verification
REQ-029 Reset with keyb_char=0000001Ch, release -> no push; empty stays 1.
REQ-030 keyb_char 1Ch then 0000F01Ch -> one push, ascii_out=61h ('a') two cycles after first change, count=1.
REQ-031 Make 12h, make 16h, break 0000F012h, make 1Eh -> FIFO holds 21h ('!') then 32h ('2').
REQ-032 Make 58h, make 1Ch, shift make 12h, make 1Ch (via intervening break) -> 41h then 61h; caps_on=1.
REQ-033 DEPTH+1 mapped makes with no reads -> full=1, count=DEPTH, overflow=1, head = first char; clr_ovf -> overflow=0.
REQ-034 Full FIFO, push and rd_en same cycle -> count stays DEPTH, overflow 0, new head = second char; rd_en on empty -> no change.

Source files
------------

// File: rtl/keyb_decoder.sv
// PS/2 set-2 scancode to ASCII decoder with a show-ahead character FIFO.
// Detects code changes, tracks shift/caps, and queues translated makes for the CPU.
module keyb_decoder #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] keyb_char,
  input  logic        rd_en,
  input  logic        clr_ovf,
  output logic [7:0]  ascii_out,
  output logic        empty,
  output logic        full,
  output logic [4:0]  count,
  output logic        overflow,
  output logic        caps_on
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [31:0]   r_prev_char;
  logic          r_armed;
  logic          r_shift_l;
  logic          r_shift_r;
  logic          r_caps;
  logic          r_pend_valid;
  logic [7:0]    r_pend_char;
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [4:0]    r_count;
  logic          r_ovf;

  logic       w_event;
  logic       w_make;
  logic       w_break;
  logic       w_shift;
  logic       w_mapped;
  logic [7:0] w_char;
  logic       w_pop;
  logic       w_push_ok;
  logic       w_drop;

  // The post-reset code is absorbed: no event until the first clock after reset.
  assign w_event = r_armed && (keyb_char != r_prev_char);
  assign w_make  = (keyb_char[23:8] == 16'h0000);
  assign w_break = (keyb_char[23:8] == 16'h00F0);
  assign w_shift = r_shift_l | r_shift_r;

  always_comb begin
    w_char   = 8'h00;
    w_mapped = 1'b1;
    case (keyb_char[7:0])
      8'h1C: w_char = 8'h61;  8'h32: w_char = 8'h62;  8'h21: w_char = 8'h63;
      8'h23: w_char = 8'h64;  8'h24: w_char = 8'h65;  8'h2B: w_char = 8'h66;
      8'h34: w_char = 8'h67;  8'h33: w_char = 8'h68;  8'h43: w_char = 8'h69;
      8'h3B: w_char = 8'h6A;  8'h42: w_char = 8'h6B;  8'h4B: w_char = 8'h6C;
      8'h3A: w_char = 8'h6D;  8'h31: w_char = 8'h6E;  8'h44: w_char = 8'h6F;
      8'h4D: w_char = 8'h70;  8'h15: w_char = 8'h71;  8'h2D: w_char = 8'h72;
      8'h1B: w_char = 8'h73;  8'h2C: w_char = 8'h74;  8'h3C: w_char = 8'h75;
      8'h2A: w_char = 8'h76;  8'h1D: w_char = 8'h77;  8'h22: w_char = 8'h78;
      8'h35: w_char = 8'h79;  8'h1A: w_char = 8'h7A;
      8'h45: w_char = w_shift ? 8'h29 : 8'h30;
      8'h16: w_char = w_shift ? 8'h21 : 8'h31;
      8'h1E: w_char = w_shift ? 8'h40 : 8'h32;
      8'h26: w_char = w_shift ? 8'h23 : 8'h33;
      8'h25: w_char = w_shift ? 8'h24 : 8'h34;
      8'h2E: w_char = w_shift ? 8'h25 : 8'h35;
      8'h36: w_char = w_shift ? 8'h5E : 8'h36;
      8'h3D: w_char = w_shift ? 8'h26 : 8'h37;
      8'h3E: w_char = w_shift ? 8'h2A : 8'h38;
      8'h46: w_char = w_shift ? 8'h28 : 8'h39;
      8'h29: w_char = 8'h20;
      8'h5A: w_char = 8'h0D;
      8'h66: w_char = 8'h08;
      8'h0D: w_char = 8'h09;
      8'h76: w_char = 8'h1B;
      default: w_mapped = 1'b0;
    endcase
    if ((w_shift ^ r_caps) && (w_char >= 8'h61) && (w_char <= 8'h7A))
      w_char = w_char - 8'h20;
  end

  // A push into a full FIFO still lands when a pop frees the slot in the same cycle.
  assign w_pop     = rd_en && (r_count != 5'd0);
  assign w_push_ok = r_pend_valid && ((r_count != DEPTH_C) || w_pop);
  assign w_drop    = r_pend_valid && !w_push_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_char  <= 32'h0;
      r_armed      <= 1'b0;
      r_shift_l    <= 1'b0;
      r_shift_r    <= 1'b0;
      r_caps       <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_char  <= 8'h00;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= 5'd0;
      r_ovf        <= 1'b0;
    end else begin
      r_prev_char  <= keyb_char;
      r_armed      <= 1'b1;
      r_pend_valid <= 1'b0;
      if (w_event) begin
        if (w_make) begin
          case (keyb_char[7:0])
            8'h12:   r_shift_l <= 1'b1;
            8'h59:   r_shift_r <= 1'b1;
            8'h58:   r_caps    <= ~r_caps;
            default: begin
              r_pend_valid <= w_mapped;
              r_pend_char  <= w_char;
            end
          endcase
        end else if (w_break) begin
          if (keyb_char[7:0] == 8'h12) r_shift_l <= 1'b0;
          if (keyb_char[7:0] == 8'h59) r_shift_r <= 1'b0;
        end
      end
      if (w_pop)     r_rptr <= r_rptr + PW'(1);
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= r_pend_char;
  end

  assign empty     = (r_count == 5'd0);
  assign full      = (r_count == DEPTH_C);
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign caps_on   = r_caps;
  assign ascii_out = empty ? 8'h00 : r_mem[r_rptr];

endmodule
